// File: rtl/instruction_decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU control,
// result-source and immediate-format selectors, and the decoded control bundle.
package instruction_decode_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC1 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic        reg_write;
    imm_src_e    imm_src;
    logic        alu_src;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    alu_op_e     alu_op;
    logic        jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{1'b0, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALUOP_ADD, 1'b0};

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: async clear, one write port, two combinational read
// ports with write-through bypass so a same-cycle writeback is visible.
module register_file
  import instruction_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        we,
  input  logic [4:0]  rd,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_r [32];
  logic        wr_en_s;

  assign wr_en_s = we && (rd != 5'd0);

  // Register array storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wr_en_s) begin
      regs_r[rd] <= wd;
    end
  end

  // Read ports: x0 is hard zero, a matching writeback bypasses the array.
  always_comb begin
    rd1 = 32'd0;
    rd2 = 32'd0;
    if (rs1 == 5'd0) begin
      rd1 = 32'd0;
    end else if (wr_en_s && (rd == rs1)) begin
      rd1 = wd;
    end else begin
      rd1 = regs_r[rs1];
    end
    if (rs2 == 5'd0) begin
      rd2 = 32'd0;
    end else if (wr_en_s && (rd == rs2)) begin
      rd2 = wd;
    end else begin
      rd2 = regs_r[rs2];
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage of the RV32I pipeline: control/ALU decode, immediate extend,
// register-file read and the ID/EX pipeline register with bubble flush.
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_IR,
  input  logic [31:0] IF_ID_PC,
  input  logic [31:0] IF_ID_PC1,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus1E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE
);

  ctrl_t       ctrl_s;
  alu_ctrl_e   alu_ctrl_s;
  logic [31:0] imm_ext_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_j_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;

  assign opcode_s = IF_ID_IR[6:0];
  assign funct3_s = IF_ID_IR[14:12];

  register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .rs1 (IF_ID_IR[19:15]),
    .rs2 (IF_ID_IR[24:20]),
    .we  (RegWriteW),
    .rd  (RdW),
    .wd  (ResultW),
    .rd1 (rd1_s),
    .rd2 (rd2_s)
  );

  // Main control decode from the opcode.
  always_comb begin
    ctrl_s = CTRL_NOP;
    case (opcode_s)
      OP_LW:   ctrl_s = '{1'b1, IMM_I, 1'b1, 1'b0, RES_MEM, 1'b0, ALUOP_ADD,   1'b0};
      OP_SW:   ctrl_s = '{1'b0, IMM_S, 1'b1, 1'b1, RES_ALU, 1'b0, ALUOP_ADD,   1'b0};
      OP_R:    ctrl_s = '{1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALUOP_FUNCT, 1'b0};
      OP_I:    ctrl_s = '{1'b1, IMM_I, 1'b1, 1'b0, RES_ALU, 1'b0, ALUOP_FUNCT, 1'b0};
      OP_BEQ:  ctrl_s = '{1'b0, IMM_B, 1'b0, 1'b0, RES_ALU, 1'b1, ALUOP_SUB,   1'b0};
      OP_JAL:  ctrl_s = '{1'b1, IMM_J, 1'b0, 1'b0, RES_PC1, 1'b0, ALUOP_ADD,   1'b1};
      default: ctrl_s = CTRL_NOP;
    endcase
  end

  // ALU operation select from ALUOp and funct3/funct7[5].
  always_comb begin
    alu_ctrl_s = ALU_ADD;
    case (ctrl_s.alu_op)
      ALUOP_ADD: alu_ctrl_s = ALU_ADD;
      ALUOP_SUB: alu_ctrl_s = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_s)
          3'b000: begin
            if ((opcode_s == OP_R) && IF_ID_IR[30]) begin
              alu_ctrl_s = ALU_SUB;
            end else begin
              alu_ctrl_s = ALU_ADD;
            end
          end
          3'b010:  alu_ctrl_s = ALU_SLT;
          3'b100:  alu_ctrl_s = ALU_XOR;
          3'b110:  alu_ctrl_s = ALU_OR;
          3'b111:  alu_ctrl_s = ALU_AND;
          default: alu_ctrl_s = ALU_ADD;
        endcase
      end
      default: alu_ctrl_s = ALU_ADD;
    endcase
  end

  // B/J offsets are byte offsets; the PC counts words, hence the >>>2.
  assign imm_b_s = {{19{IF_ID_IR[31]}}, IF_ID_IR[31], IF_ID_IR[7], IF_ID_IR[30:25],
                    IF_ID_IR[11:8], 1'b0};
  assign imm_j_s = {{11{IF_ID_IR[31]}}, IF_ID_IR[31], IF_ID_IR[19:12], IF_ID_IR[20],
                    IF_ID_IR[30:21], 1'b0};

  // Immediate extension by format.
  always_comb begin
    imm_ext_s = 32'd0;
    case (ctrl_s.imm_src)
      IMM_I:   imm_ext_s = {{20{IF_ID_IR[31]}}, IF_ID_IR[31:20]};
      IMM_S:   imm_ext_s = {{20{IF_ID_IR[31]}}, IF_ID_IR[31:25], IF_ID_IR[11:7]};
      IMM_B:   imm_ext_s = {{2{imm_b_s[31]}}, imm_b_s[31:2]};
      IMM_J:   imm_ext_s = {{2{imm_j_s[31]}}, imm_j_s[31:2]};
      default: imm_ext_s = 32'd0;
    endcase
  end

  // ID/EX pipeline register; reset and flush both load a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      RD1E        <= 32'd0;
      RD2E        <= 32'd0;
      ImmExtE     <= 32'd0;
      PCE         <= 32'd0;
      PCPlus1E    <= 32'd0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
      RdE         <= 5'd0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
    end else begin
      RD1E        <= rd1_s;
      RD2E        <= rd2_s;
      ImmExtE     <= imm_ext_s;
      PCE         <= IF_ID_PC;
      PCPlus1E    <= IF_ID_PC1;
      Rs1E        <= IF_ID_IR[19:15];
      Rs2E        <= IF_ID_IR[24:20];
      RdE         <= IF_ID_IR[11:7];
      RegWriteE   <= ctrl_s.reg_write;
      MemWriteE   <= ctrl_s.mem_write;
      JumpE       <= ctrl_s.jump;
      BranchE     <= ctrl_s.branch;
      ALUSrcE     <= ctrl_s.alu_src;
      ResultSrcE  <= ctrl_s.result_src;
      ALUControlE <= alu_ctrl_s;
    end
  end

endmodule
